// File: rtl/peres_pkg.sv
// Shared types and constants for the Peres-gate serial adder.
// The helper function models a single reversible Peres gate.
package peres_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W  = 4;
    localparam int GARB_W = 8;

    // Peres gate: (a, b, c) -> {P, Q, R} = {a, a^b, (a&b)^c}
    function automatic logic [2:0] peres(input logic a, input logic b, input logic c);
        return {a, a ^ b, (a & b) ^ c};
    endfunction

endpackage

// File: rtl/peres_fa4.sv
// Combinational 4-bit ripple adder built from two cascaded Peres gates per bit.
// Garbage lines are exported as {a, a^b} for signature accumulation.
module peres_fa4
    import peres_pkg::*;
(
    input  logic [NIB_W-1:0]  a,
    input  logic [NIB_W-1:0]  b,
    input  logic              cin,
    output logic [NIB_W-1:0]  sum,
    output logic              cout,
    output logic [GARB_W-1:0] garb
);

    logic [NIB_W:0]   c;
    logic [NIB_W-1:0] axb;
    logic [NIB_W-1:0] ab;
    logic [2:0]       g1;
    logic [2:0]       g2;

    always_comb begin
        c    = '0;
        c[0] = cin;
        axb  = '0;
        ab   = '0;
        sum  = '0;
        g1   = '0;
        g2   = '0;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            // Gate 1 with a zero ancilla yields a^b and a&b; gate 2 folds in the carry.
            g1       = peres(a[i], b[i], 1'b0);
            axb[i]   = g1[1];
            ab[i]    = g1[0];
            g2       = peres(axb[i], c[i], ab[i]);
            sum[i]   = g2[1];
            c[i+1]   = g2[0];
        end
    end

    assign cout = c[NIB_W];
    assign garb = {a, axb};

endmodule

// File: rtl/peres_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared Peres nibble stage,
// with valid/ready handshakes on both sides and a garbage-line XOR signature.
module peres_serial_adder
    import peres_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic [GARB_W-1:0] garb_sig
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("peres_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] nib_idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic             last_nib;

    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [NIB_W-1:0]  s_nib;
    logic              c_nib;
    logic [GARB_W-1:0] garb;

    assign a_nib    = a_r[nib_idx*NIB_W +: NIB_W];
    assign b_nib    = b_r[nib_idx*NIB_W +: NIB_W];
    assign last_nib = (nib_idx == IDX_W'(NIB - 1));

    peres_fa4 u_fa4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_nib),
        .garb (garb)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last_nib) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            nib_idx  <= '0;
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            garb_sig <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= cin;
                        nib_idx  <= '0;
                        sum      <= '0;
                        garb_sig <= '0;
                    end
                end
                RUN: begin
                    sum[nib_idx*NIB_W +: NIB_W] <= s_nib;
                    carry                       <= c_nib;
                    garb_sig                    <= garb_sig ^ garb;
                    nib_idx                     <= nib_idx + IDX_W'(1);
                    if (last_nib) cout <= c_nib;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peres_serial_adder.sv
// Self-checking bench: table-driven 16-bit vectors, handshake corner sequences,
// and random sweeps at WIDTH=4 and WIDTH=32, with a scoreboard queue of expected results.
module tb_peres_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, ci16 = 1'b0, co16;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic [7:0]  g16;
    // WIDTH=4 instance
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, ci4 = 1'b0, co4;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic [7:0]  g4;
    // WIDTH=32 instance
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, ci32 = 1'b0, co32;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic [7:0]  g32;

    peres_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .garb_sig(g16));
    peres_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .garb_sig(g4));
    peres_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(ci32),
        .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .garb_sig(g32));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic [7:0]  g;
    } vec_t;

    vec_t        vecs[6];
    logic [32:0] sb[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen (or budget spent).
    task automatic wait_out16(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov16 && lat < 50);
        check("out_valid16_seen", {63'd0, ov16}, 64'd1);
    endtask

    task automatic run16(input vec_t v, input string nm);
        int lat;
        logic [32:0] e;
        for (int k = 0; k < 20 && !ir16; k++) @(negedge clk);
        a16 = v.a; b16 = v.b; ci16 = v.cin; iv16 = 1'b1;
        sb.push_back({16'd0, v.co, v.s});
        @(posedge clk);
        #1 iv16 = 1'b0;
        wait_out16(lat);
        check({nm, "_latency"}, 64'(lat), 64'd4);
        e = sb.pop_front();
        check({nm, "_sum_cout"}, {47'd0, co16, s16}, {31'd0, e});
        check({nm, "_garb"}, {56'd0, g16}, {56'd0, v.g});
        or16 = 1'b1;
        @(posedge clk);
        #1 or16 = 1'b0;
        @(negedge clk);
        check({nm, "_ready_after"}, {62'd0, ir16, ov16}, 64'd2);
    endtask

    initial begin
        int lat;
        logic [32:0] e;
        logic [15:0] held;

        vecs[0] = '{a:16'h00FF, b:16'h0001, cin:1'b0, s:16'h0100, co:1'b0, g:8'h01};
        vecs[1] = '{a:16'hFFFF, b:16'h0000, cin:1'b1, s:16'h0000, co:1'b1, g:8'h00};
        vecs[2] = '{a:16'h1234, b:16'h4321, cin:1'b0, s:16'h5555, co:1'b0, g:8'h40};
        vecs[3] = '{a:16'h0001, b:16'h0000, cin:1'b0, s:16'h0001, co:1'b0, g:8'h11};
        vecs[4] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, s:16'hFFFF, co:1'b1, g:8'h00};
        vecs[5] = '{a:16'hABCD, b:16'h1111, cin:1'b1, s:16'hBCDF, co:1'b0, g:8'h00};

        // Reset state (in_ready decodes from IDLE, so it is 1 during reset)
        @(negedge clk);
        check("reset_outputs", {g16, co16, s16, ov16, ir16}, {8'h00, 1'b0, 16'h0000, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run16(vecs[i], $sformatf("vec%0d", i));

        // Stall: result held for 5 cycles while new in_valid is ignored
        a16 = 16'h8000; b16 = 16'h8000; ci16 = 1'b0; iv16 = 1'b1;
        sb.push_back({16'd0, 1'b1, 16'h0000});
        @(posedge clk);
        #1 iv16 = 1'b0;
        wait_out16(lat);
        e = sb.pop_front();
        held = s16;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_state", k), {62'd0, ov16, ir16}, 64'd2);
            check($sformatf("stall%0d_sum_cout", k), {47'd0, co16, s16}, {31'd0, e});
            a16 = 16'h1111; b16 = 16'h2222; iv16 = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("stall_held", {48'd0, s16}, {48'd0, held});
        iv16 = 1'b0; or16 = 1'b1;
        @(posedge clk);
        #1 or16 = 1'b0;
        @(negedge clk);
        check("stall_release", {62'd0, ir16, ov16}, 64'd2);
        @(negedge clk);
        check("stall_no_accept", {63'd0, ir16}, 64'd1);

        // Back-to-back with in_valid and out_ready held high
        a16 = 16'h0001; b16 = 16'h0001; ci16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
        sb.push_back({16'd0, 1'b0, 16'h0002});
        @(posedge clk);
        wait_out16(lat);
        check("b2b_first_latency", 64'(lat), 64'd4);
        e = sb.pop_front();
        check("b2b_first", {47'd0, co16, s16}, {31'd0, e});
        a16 = 16'h7FFF; b16 = 16'h0001;
        sb.push_back({16'd0, 1'b0, 16'h8000});
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle_after_handshake", {62'd0, ir16, ov16}, 64'd2);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_accepted", {63'd0, ir16}, 64'd0);
        iv16 = 1'b0;
        wait_out16(lat);
        check("b2b_second_latency", 64'(lat), 64'd4);
        e = sb.pop_front();
        check("b2b_second", {47'd0, co16, s16}, {31'd0, e});
        @(posedge clk);
        #1 or16 = 1'b0;
        @(negedge clk);

        // Reset two cycles into RUN discards the operation
        a16 = 16'hAAAA; b16 = 16'h5555; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset", {g16, co16, s16, ov16, ir16}, {8'h00, 1'b0, 16'h0000, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run16(vecs[2], "post_reset");

        // Random sweep, WIDTH=4
        for (int i = 0; i < 24; i++) begin
            int n;
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); iv4 = 1'b1;
            sb.push_back(33'(a4) + 33'(b4) + 33'(ci4));
            @(posedge clk);
            #1 iv4 = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!ov4 && n < 20);
            e = sb.pop_front();
            check($sformatf("w4_rand%0d", i), {58'd0, ov4, co4, s4}, {58'd0, 1'b1, e[4:0]});
            or4 = 1'b1;
            @(posedge clk);
            #1 or4 = 1'b0;
            @(negedge clk);
        end

        // Random sweep, WIDTH=32
        for (int i = 0; i < 24; i++) begin
            int n;
            a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); iv32 = 1'b1;
            if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; ci32 = 1'b1; end
            sb.push_back(33'(a32) + 33'(b32) + 33'(ci32));
            @(posedge clk);
            #1 iv32 = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!ov32 && n < 40);
            e = sb.pop_front();
            check($sformatf("w32_rand%0d", i), {30'd0, ov32, co32, s32}, {30'd0, 1'b1, e});
            or32 = 1'b1;
            @(posedge clk);
            #1 or32 = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
